// File: rtl/i2c_e2prom_slave.sv
// I2C target emulating a 16-bit-word-address serial EEPROM backed by internal RAM.
// Optional write protect: define E2P_WP_EN to add the wp input (NACKs and drops data bytes).
module i2c_e2prom_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
    parameter int         MEM_AW     = 8,
    parameter int         FILT_LEN   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl,
    input  logic              sda_in,
`ifdef E2P_WP_EN
    input  logic              wp,
`endif
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_stb,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int           CW      = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEV_ADDR = 3'd1;
    localparam logic [2:0] S_ADDR_HI  = 3'd2;
    localparam logic [2:0] S_ADDR_LO  = 3'd3;
    localparam logic [2:0] S_WR_DATA  = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;
    localparam logic [2:0] S_RD_MACK  = 3'd6;

    logic [1:0]        r_scl_sync, r_sda_sync;
    logic [CW-1:0]     r_scl_cnt, r_sda_cnt;
    logic              r_scl_f, r_sda_f, r_scl_d, r_sda_d;
    logic [2:0]        r_state, r_next_state;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_addr_hi;
    logic [MEM_AW-1:0] r_ptr;
    logic              r_ack_go;
    logic              r_sda_oe, r_busy, r_wr_stb;
    logic [MEM_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_mem [0:(1<<MEM_AW)-1];

    logic              w_scl_rise, w_scl_fall, w_start, w_stop;
    logic              w_wp, w_mem_we, w_unused;
    logic [7:0]        w_byte, w_rd_byte;
    logic [15:0]       w_word_addr;

`ifdef E2P_WP_EN
    assign w_wp = wp;
`else
    assign w_wp = 1'b0;
`endif

    // A synchronized level is accepted only after it differs from the filtered one for FILT_LEN clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl};
            r_sda_sync <= {r_sda_sync[0], sda_in};
            r_scl_d    <= r_scl_f;
            r_sda_d    <= r_sda_f;
            if (r_scl_sync[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == CNT_MAX) begin
                r_scl_f   <= r_scl_sync[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + CW'(1);
            end
            if (r_sda_sync[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == CNT_MAX) begin
                r_sda_f   <= r_sda_sync[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + CW'(1);
            end
        end
    end

    assign w_scl_rise  = r_scl_f & ~r_scl_d;
    assign w_scl_fall  = ~r_scl_f & r_scl_d;
    assign w_start     = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
    assign w_stop      = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
    assign w_byte      = {r_shift[6:0], r_sda_f};
    assign w_rd_byte   = r_mem[r_ptr];
    assign w_word_addr = {r_addr_hi, w_byte};
    assign w_mem_we    = (r_state == S_WR_DATA) && w_scl_rise && (r_bit_cnt == 4'd7) && !w_wp;
    assign w_unused    = ^{w_word_addr, r_shift[7]};

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    // bit_cnt: 0..7 data bits, 8 = waiting for the ACK-slot fall, 9 = inside the ACK slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_next_state <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_addr_hi    <= 8'h00;
            r_ptr        <= '0;
            r_ack_go     <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_wr_stb     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 8'h00;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_state   <= S_DEV_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_scl_rise) begin
                    if (r_bit_cnt < 4'd8) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_state != S_RD_DATA) begin
                            r_shift <= w_byte;
                        end
                        if (r_bit_cnt == 4'd7) begin
                            case (r_state)
                                S_DEV_ADDR: begin
                                    if (w_byte[7:1] == SLAVE_ADDR) begin
                                        r_ack_go     <= 1'b1;
                                        r_next_state <= w_byte[0] ? S_RD_DATA : S_ADDR_HI;
                                    end else begin
                                        r_ack_go <= 1'b0;
                                        r_state  <= S_IDLE;
                                    end
                                end
                                S_ADDR_HI: begin
                                    r_addr_hi    <= w_byte;
                                    r_ack_go     <= 1'b1;
                                    r_next_state <= S_ADDR_LO;
                                end
                                S_ADDR_LO: begin
                                    r_ptr        <= w_word_addr[MEM_AW-1:0];
                                    r_ack_go     <= 1'b1;
                                    r_next_state <= S_WR_DATA;
                                end
                                S_WR_DATA: begin
                                    r_ack_go     <= !w_wp;
                                    r_next_state <= S_WR_DATA;
                                    if (!w_wp) begin
                                        r_wr_stb  <= 1'b1;
                                        r_wr_addr <= r_ptr;
                                        r_wr_data <= w_byte;
                                        r_ptr     <= r_ptr + MEM_AW'(1);
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (r_bit_cnt == 4'd8) begin
                        r_bit_cnt <= 4'd9;
                        if (r_state == S_RD_MACK) begin
                            if (r_sda_f) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_ptr <= r_ptr + MEM_AW'(1);
                            end
                        end
                    end
                end else if (w_scl_fall) begin
                    if (r_state == S_RD_DATA) begin
                        if (r_bit_cnt == 4'd8) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= S_RD_MACK;
                        end else if (r_bit_cnt != 4'd0) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                    end else if (r_state == S_RD_MACK) begin
                        if (r_bit_cnt == 4'd9) begin
                            r_state   <= S_RD_DATA;
                            r_bit_cnt <= 4'd0;
                            r_shift   <= w_rd_byte;
                            r_sda_oe  <= ~w_rd_byte[7];
                        end
                    end else if (r_bit_cnt == 4'd8) begin
                        r_sda_oe <= r_ack_go;
                        if (r_state == S_DEV_ADDR) begin
                            r_busy <= 1'b1;
                        end
                    end else if (r_bit_cnt == 4'd9) begin
                        r_bit_cnt <= 4'd0;
                        r_state   <= r_next_state;
                        if (r_next_state == S_RD_DATA) begin
                            r_shift  <= w_rd_byte;
                            r_sda_oe <= ~w_rd_byte[7];
                        end else begin
                            r_sda_oe <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_i2c_e2prom_slave.sv
// Bench for i2c_e2prom_slave: bit-banged I2C master, open-drain bus model and queue scoreboard.
module tb_i2c_e2prom_slave;

    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe, busy, wr_stb;
    logic [7:0] wr_addr, wr_data;
`ifdef E2P_WP_EN
    logic       wp = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int oe_viol = 0;
    logic watch_no_oe = 1'b0;

    logic [15:0] exp_q[$];
    logic        exp_ack_q[$];
    logic        obs_ack_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  obs_rd_q[$];

    assign sda_bus = m_sda & ~sda_oe;

    i2c_e2prom_slave #(
        .SLAVE_ADDR (7'b1010000),
        .MEM_AW     (8),
        .FILT_LEN   (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl     (m_scl),
        .sda_in  (sda_bus),
`ifdef E2P_WP_EN
        .wp      (wp),
`endif
        .sda_oe  (sda_oe),
        .busy    (busy),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: commits, ACK bits and read bytes are compared as they appear.
    always @(negedge clk) begin
        if (rst_n && wr_stb) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual=%0h required=none", {wr_addr, wr_data});
            end else begin
                check("wr_commit", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
        if (obs_ack_q.size() > 0 && exp_ack_q.size() > 0) begin
            check("ack", obs_ack_q.pop_front(), exp_ack_q.pop_front());
        end
        if (obs_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
            check("rd_data", obs_rd_q.pop_front(), exp_rd_q.pop_front());
        end
        if (watch_no_oe && sda_oe) begin
            oe_viol++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; tick(Q);
            m_scl = 1'b1; tick(2 * Q);
            m_scl = 1'b0; tick(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        exp_ack_q.push_back(exp_ack);
        send_bits(b, 8);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        obs_ack_q.push_back(~sda_bus);
        tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic master_ack);
        logic [7:0] b;
        b = 8'h00;
        exp_rd_q.push_back(exp);
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(Q);
            m_scl = 1'b1; tick(Q);
            b = {b[6:0], sda_bus};
            tick(Q);
            m_scl = 1'b0; tick(Q);
        end
        obs_rd_q.push_back(b);
        m_sda = ~master_ack; tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
        m_sda = 1'b1;
    endtask

    task automatic set_pointer(input logic [7:0] lo);
        i2c_start();
        write_byte(8'hA0, 1'b1);
        write_byte(8'h00, 1'b1);
        write_byte(lo, 1'b1);
    endtask

    initial begin
        tick(5);
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_wr_stb", wr_stb, 1'b0);
        check("reset_wr_addr", wr_addr, 8'h00);
        check("reset_wr_data", wr_data, 8'h00);
        rst_n = 1'b1;
        tick(10);

        // Byte write 0x12 <= 0x5A
        exp_q.push_back(16'h125A);
        i2c_start();
        write_byte(8'hA0, 1'b1);
        check("busy_after_addr_ack", busy, 1'b1);
        write_byte(8'h00, 1'b1);
        write_byte(8'h12, 1'b1);
        write_byte(8'h5A, 1'b1);
        i2c_stop();
        check("busy_after_stop", busy, 1'b0);

        // Byte write 0x30 <= 0xC3
        exp_q.push_back(16'h30C3);
        set_pointer(8'h30);
        write_byte(8'hC3, 1'b1);
        i2c_stop();

        // Random read of 0x12, master NACK
        set_pointer(8'h12);
        i2c_start();
        write_byte(8'hA1, 1'b1);
        read_byte(8'h5A, 1'b0);
        tick(4);
        check("busy_after_nack", busy, 1'b0);
        i2c_stop();

        // Sequential write across the wrap point
        exp_q.push_back(16'hFE11);
        exp_q.push_back(16'hFF22);
        exp_q.push_back(16'h0033);
        set_pointer(8'hFE);
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        i2c_stop();

        // Sequential read across the wrap point
        set_pointer(8'hFE);
        i2c_start();
        write_byte(8'hA1, 1'b1);
        read_byte(8'h11, 1'b1);
        check("busy_mid_read", busy, 1'b1);
        read_byte(8'h22, 1'b1);
        read_byte(8'h33, 1'b0);
        i2c_stop();

        // Current-address read: pointer stayed on 0x00 after the NACKed byte
        i2c_start();
        write_byte(8'hA1, 1'b1);
        read_byte(8'h33, 1'b0);
        i2c_stop();

        // Wrong device address
        watch_no_oe = 1'b1;
        i2c_start();
        write_byte(8'hA4, 1'b0);
        write_byte(8'h00, 1'b0);
        write_byte(8'h12, 1'b0);
        check("busy_wrong_addr", busy, 1'b0);
        i2c_stop();
        watch_no_oe = 1'b0;
        check("no_oe_wrong_addr", oe_viol, 0);

        // Partial data byte aborted by STOP leaves RAM[0x30] intact
        set_pointer(8'h30);
        send_bits(8'hF0, 4);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, 1'b1);
        read_byte(8'hC3, 1'b0);
        i2c_stop();

        // Reset in the middle of a read while SDA is held low
        i2c_start();
        write_byte(8'hA1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(Q);
            m_scl = 1'b1; tick(2 * Q);
            m_scl = 1'b0; tick(Q);
        end
        tick(Q);
        check("oe_before_reset", sda_oe, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("oe_during_reset", sda_oe, 1'b0);
        check("busy_during_reset", busy, 1'b0);
        tick(5);
        rst_n = 1'b1;
        tick(5);
        check("wr_addr_after_reset", wr_addr, 8'h00);
        i2c_stop();

        // Pointer reset to 0, RAM retained
        i2c_start();
        write_byte(8'hA1, 1'b1);
        read_byte(8'h33, 1'b0);
        i2c_stop();

`ifdef E2P_WP_EN
        exp_q.push_back(16'h2066);
        set_pointer(8'h20);
        write_byte(8'h66, 1'b1);
        i2c_stop();
        wp = 1'b1;
        set_pointer(8'h20);
        write_byte(8'h77, 1'b0);
        i2c_stop();
        wp = 1'b0;
        set_pointer(8'h20);
        i2c_start();
        write_byte(8'hA1, 1'b1);
        read_byte(8'h66, 1'b0);
        i2c_stop();
`endif

        tick(50);
        check("exp_wr_drained", exp_q.size(), 0);
        check("exp_ack_drained", exp_ack_q.size(), 0);
        check("exp_rd_drained", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
